// File: rtl/text_buffer_ctrl_if.sv
// Write-port bundle shared by the two requesters and the text buffer controller.
// Requesters hold req/addr/data until they see their gnt.
`timescale 1ns/1ps
interface text_buffer_ctrl_if;
    logic       req0;
    logic       req1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [6:0] data0;
    logic [6:0] data1;
    logic       gnt0;
    logic       gnt1;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  gnt0, gnt1
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output gnt0, gnt1
    );
endinterface

// File: rtl/text_buffer_ctrl.sv
// 256x7 character buffer with a registered display read port.
// A two-requester round-robin write port shares the buffer with a full-screen clear sequencer.
`timescale 1ns/1ps
module text_buffer_ctrl #(
    parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
    input  logic                     clk,
    input  logic                     rst,
    text_buffer_ctrl_if.slave        wr,
    input  logic [7:0]               char_yx,
    output logic [6:0]               char_code,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clear_done
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state_q;
    logic       ptr_q;
    logic [7:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [6:0] char_code_q;
    logic [6:0] mem [256];

    logic       idle_accept;
    logic       gnt0_d;
    logic       gnt1_d;
    logic       we_d;
    logic [7:0] waddr_d;
    logic [6:0] wdata_d;

    // Grants are combinational but gated by reset so they drop without a clock edge.
    assign idle_accept = rst && (state_q == IDLE) && !clear_req;
    assign gnt0_d      = idle_accept && wr.req0 && (!wr.req1 || !ptr_q);
    assign gnt1_d      = idle_accept && wr.req1 && (!wr.req0 ||  ptr_q);

    assign wr.gnt0    = gnt0_d;
    assign wr.gnt1    = gnt1_d;
    assign busy       = busy_q;
    assign clear_done = done_q;
    assign char_code  = char_code_q;

    always_comb begin
        we_d    = 1'b0;
        waddr_d = 8'd0;
        wdata_d = 7'd0;
        if (rst && state_q == CLEAR) begin
            we_d    = 1'b1;
            waddr_d = cnt_q;
            wdata_d = CLEAR_CHAR;
        end else if (gnt0_d) begin
            we_d    = 1'b1;
            waddr_d = wr.addr0;
            wdata_d = wr.data0;
        end else if (gnt1_d) begin
            we_d    = 1'b1;
            waddr_d = wr.addr1;
            wdata_d = wr.data1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                    end else if (wr.req0 && wr.req1) begin
                        ptr_q <= ~ptr_q;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_q == 8'hFF) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Buffer contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we_d) begin
            mem[waddr_d] <= wdata_d;
        end
    end

    // Read-before-write falls out of the non-blocking read against the same-edge write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_code_q <= 7'd0;
        end else begin
            char_code_q <= mem[char_yx];
        end
    end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Scoreboard bench for text_buffer_ctrl: reads push expected codes from a reference
// buffer image and the registered char_code is popped and compared one clock later.
`timescale 1ns/1ps
module tb_text_buffer_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] char_yx;
    logic [6:0] char_code;
    logic       clear_req;
    logic       busy;
    logic       clear_done;

    text_buffer_ctrl_if bus ();

    text_buffer_ctrl #(.CLEAR_CHAR(7'h20)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (bus),
        .char_yx    (char_yx),
        .char_code  (char_code),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] model [256];
    logic [6:0] exp_q [$];
    logic       exp_ptr = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; clear_req = 1'b0; char_yx = 8'h00;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 8'h00; bus.addr1 = 8'h01; bus.data0 = 7'h00; bus.data1 = 7'h00;
        #3;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (clear_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", clear_done); end
        vectors++; if (bus.gnt0 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt0: got %b want 0", bus.gnt0); end
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt1: got %b want 0", bus.gnt1); end
        tick();
        vectors++; if (char_code !== 7'h00) begin miscompares++; $display("FAIL reset_char_code: got %h want 00", char_code); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        rst = 1'b1;
        $display("reset: outputs checked while rst low");
    endtask

    task automatic test_clear();
        int busy_cycles = 0;
        bit done_seen = 1'b0;
        logic [7:0] rd_addr [5];
        rd_addr[0] = 8'h00; rd_addr[1] = 8'h35; rd_addr[2] = 8'h7F; rd_addr[3] = 8'hFF;
        rd_addr[4] = 8'($urandom_range(0, 255));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            @(negedge clk);
            if (clear_done === 1'b1) begin
                done_seen = 1'b1;
                vectors++;
                if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_exit_busy: got %b want 0", busy); end
            end else if (busy === 1'b1) begin
                busy_cycles++;
            end
            tick();
            clear_req = (c == 50);
        end
        clear_req = 1'b0;
        vectors++; if (!done_seen) begin miscompares++; $display("FAIL clear_timeout: clear_done got none want pulse"); end
        vectors++; if (busy_cycles != 256) begin miscompares++; $display("FAIL clear_busy_len: got %0d want 256", busy_cycles); end
        @(negedge clk);
        vectors++; if (clear_done !== 1'b0) begin miscompares++; $display("FAIL clear_done_width: got %b want 0", clear_done); end
        for (int i = 0; i < 256; i++) model[i] = 7'h20;
        $display("clear: busy for %0d cycles, clear_done seen=%0b", busy_cycles, done_seen);
        tick();
        for (int i = 0; i < 5; i++) begin
            char_yx = rd_addr[i];
            exp_q.push_back(model[rd_addr[i]]);
            tick();
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++; $display("FAIL clear_read_underflow: got empty want entry");
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if (char_code !== e) begin miscompares++; $display("FAIL clear_read[%h]: got %h want %h", rd_addr[i], char_code, e); end
                else $display("read %h -> %h", rd_addr[i], char_code);
            end
        end
    endtask

    task automatic test_single_write();
        logic [6:0] e;
        bus.req0 = 1'b1; bus.addr0 = 8'h35; bus.data0 = 7'h41;
        @(negedge clk);
        vectors++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0)
            begin miscompares++; $display("FAIL single_gnt: got %b%b want 10", bus.gnt0, bus.gnt1); end
        tick();
        model[8'h35] = 7'h41;
        bus.req0 = 1'b0;
        char_yx = 8'h35;
        exp_q.push_back(model[8'h35]);
        tick();
        e = exp_q.pop_front();
        vectors++; if (char_code !== e) begin miscompares++; $display("FAIL single_read: got %h want %h", char_code, e); end
        $display("single write 35<=41, read back %h", char_code);
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd_addr [4];
        rd_addr[0] = 8'h50; rd_addr[1] = 8'h51; rd_addr[2] = 8'h60; rd_addr[3] = 8'h61;
        bus.req0 = 1'b1; bus.addr0 = 8'h50; bus.data0 = 7'h01;
        bus.req1 = 1'b1; bus.addr1 = 8'h60; bus.data1 = 7'h02;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.gnt0 !== !exp_ptr || bus.gnt1 !== exp_ptr) begin
                miscompares++;
                $display("FAIL contest_gnt[%0d]: got %b%b want %b%b", k, bus.gnt0, bus.gnt1, !exp_ptr, exp_ptr);
            end else begin
                $display("contest %0d: gnt0=%b gnt1=%b", k, bus.gnt0, bus.gnt1);
            end
            if (!exp_ptr) model[bus.addr0] = bus.data0;
            else          model[bus.addr1] = bus.data1;
            tick();
            if (!exp_ptr) begin bus.addr0 = bus.addr0 + 8'd1; bus.data0 = bus.data0 + 7'd2; end
            else          begin bus.addr1 = bus.addr1 + 8'd1; bus.data1 = bus.data1 + 7'd2; end
            exp_ptr = ~exp_ptr;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [6:0] e;
            char_yx = rd_addr[i];
            exp_q.push_back(model[rd_addr[i]]);
            tick();
            e = exp_q.pop_front();
            vectors++; if (char_code !== e) begin miscompares++; $display("FAIL contest_read[%h]: got %h want %h", rd_addr[i], char_code, e); end
            else $display("read %h -> %h", rd_addr[i], char_code);
        end
    endtask

    task automatic test_clear_vs_req();
        bit done_seen = 1'b0;
        bit early_gnt = 1'b0;
        logic [6:0] e;
        bus.req1 = 1'b1; bus.addr1 = 8'h10; bus.data1 = 7'h55;
        clear_req = 1'b1;
        @(negedge clk);
        vectors++; if (bus.gnt1 !== 1'b0) begin miscompares++; $display("FAIL clear_beats_gnt1: got %b want 0", bus.gnt1); end
        tick();
        clear_req = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_vs_req_busy: got %b want 1", busy); end
        for (int c = 0; c < 300; c++) begin
            if (c != 0) @(negedge clk);
            if (clear_done === 1'b1) begin done_seen = 1'b1; break; end
            if (bus.gnt1 !== 1'b0) early_gnt = 1'b1;
            tick();
        end
        vectors++; if (early_gnt) begin miscompares++; $display("FAIL gnt1_during_clear: got 1 want 0"); end
        vectors++; if (!done_seen || bus.gnt1 !== 1'b1)
            begin miscompares++; $display("FAIL gnt1_after_clear: done=%b gnt1=%b want 1 1", done_seen, bus.gnt1); end
        for (int i = 0; i < 256; i++) model[i] = 7'h20;
        model[8'h10] = 7'h55;
        tick();
        bus.req1 = 1'b0;
        $display("clear vs req1: gnt1 deferred until clear_done");
        for (int i = 0; i < 2; i++) begin
            char_yx = 8'h10 + 8'(i);
            exp_q.push_back(model[char_yx]);
            tick();
            e = exp_q.pop_front();
            vectors++; if (char_code !== e) begin miscompares++; $display("FAIL post_clear_read[%0d]: got %h want %h", i, char_code, e); end
        end
    endtask

    task automatic test_read_before_write();
        logic [6:0] e;
        bus.req0 = 1'b1; bus.addr0 = 8'h00; bus.data0 = 7'h7F;
        char_yx = 8'h00;
        exp_q.push_back(model[8'h00]);
        @(negedge clk);
        vectors++; if (bus.gnt0 !== 1'b1) begin miscompares++; $display("FAIL rbw_gnt0: got %b want 1", bus.gnt0); end
        tick();
        model[8'h00] = 7'h7F;
        bus.req0 = 1'b0;
        e = exp_q.pop_front();
        vectors++; if (char_code !== e) begin miscompares++; $display("FAIL rbw_old: got %h want %h", char_code, e); end
        exp_q.push_back(model[8'h00]);
        tick();
        e = exp_q.pop_front();
        vectors++; if (char_code !== e) begin miscompares++; $display("FAIL rbw_new: got %h want %h", char_code, e); end
        $display("read-before-write at 00: new code %h", char_code);
    endtask

    task automatic test_reset_mid_clear();
        bit stray = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (100) tick();
        bus.req0 = 1'b1; bus.addr0 = 8'h20; bus.data0 = 7'h11;
        #2 rst = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (bus.gnt0 !== 1'b0) begin miscompares++; $display("FAIL abort_gnt0: got %b want 0", bus.gnt0); end
        vectors++; if (char_code !== 7'h00) begin miscompares++; $display("FAIL abort_char_code: got %h want 00", char_code); end
        tick();
        tick();
        rst = 1'b1;
        bus.req0 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (clear_done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
            tick();
        end
        vectors++; if (stray) begin miscompares++; $display("FAIL abort_resume: got busy/clear_done activity want none"); end
        bus.req0 = 1'b1;
        @(negedge clk);
        vectors++; if (bus.gnt0 !== 1'b1) begin miscompares++; $display("FAIL abort_idle_gnt0: got %b want 1", bus.gnt0); end
        tick();
        bus.req0 = 1'b0;
        $display("reset during clear: aborted, back in IDLE");
    endtask

    initial begin
        test_reset();
        test_clear();
        test_single_write();
        test_back_to_back();
        test_clear_vs_req();
        test_read_before_write();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_CHAR, default 7'h20, the code written to every cell by a clear.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port char_yx  input  8  display read address {row[3:0], col[3:0]} from the char-draw stage.
REQ-005 SHALL have port char_code  output  7  the character code stored at char_yx, driven to the font ROM.
REQ-006 SHALL have ports req0, req1  input  1  write request from requester 0 or 1.
REQ-007 SHALL have ports addr0, addr1  input  8  cell address {row, col} for each requester.
REQ-008 SHALL have ports data0, data1  input  7  character code for each requester.
REQ-009 SHALL have ports gnt0, gnt1  output  1  write accepted for requester 0 or 1 in this cycle.
REQ-010 SHALL have port clear_req  input  1  request to fill the whole buffer with CLEAR_CHAR.
REQ-011 SHALL have port busy  output  1  high while a clear is in progress.
REQ-012 SHALL have port clear_done  output  1  one-cycle pulse after the last clear write.

Function
REQ-013 SHALL hold a 256 x 7 character buffer indexed {row, col}.
REQ-014 SHALL return char_code = buffer[char_yx] exactly one clk after char_yx is presented (registered read), in every state.
REQ-015 SHALL implement FSM states IDLE and CLEAR, plus a 1-bit round-robin pointer and an 8-bit clear counter.
REQ-016 In IDLE with clear_req=1, SHALL enter CLEAR, load the counter with 0 and assert no grant that cycle (clear beats writes).
REQ-017 In IDLE with clear_req=0 and only one reqK=1, SHALL assert gntK combinationally in that cycle and write dataK to addrK at the closing edge.
REQ-018 In IDLE with req0=req1=1, SHALL grant the requester the pointer selects; the pointer then selects the other requester.
REQ-019 The pointer SHALL change only on a contested grant; after reset it SHALL select requester 0.
REQ-020 At most one of gnt0/gnt1 SHALL be high in any cycle; exactly one buffer write SHALL occur per grant.
REQ-021 Requesters SHALL hold req, addr and data until they see gnt high; the block SHALL sample them only in the grant cycle.
REQ-022 In CLEAR, SHALL write CLEAR_CHAR to buffer[counter] each cycle and increment the counter, with busy=1 and gnt0=gnt1=0.
REQ-023 After writing address 255 (256 cycles in CLEAR), SHALL return to IDLE, pulse clear_done for one cycle and drop busy that cycle.
REQ-024 clear_req asserted while in CLEAR SHALL be ignored; the counter SHALL not restart.
REQ-025 A display read of the cell being written in the same cycle SHALL return the old contents (read-before-write).
REQ-026 Grants SHALL resume in the first IDLE cycle after CLEAR, using the pointer value held from before the clear.

Reset
REQ-027 While rst=0, SHALL hold the FSM in IDLE, counter=0, pointer=requester 0, busy=0, clear_done=0, gnt0=gnt1=0 and char_code=0, independent of clk.
REQ-028 Reset SHALL not initialise the buffer; contents after reset are undefined until a clear completes.
REQ-029 Reset asserted during CLEAR SHALL abort the clear immediately; after reset release the block SHALL be in IDLE with busy=0 and no clear_done pulse.

Verification
REQ-030 Reset, then clear_req pulse -> busy=1 for 256 cycles, clear_done pulse in the exit cycle; reading any char_yx afterwards returns 7'h20.
REQ-031 req0 with addr0=8'h35, data0=7'h41 in IDLE -> gnt0=1 same cycle; char_yx=8'h35 next cycle, then char_code=7'h41 one cycle later.
REQ-032 req0=req1=1 held for 4 cycles with distinct addresses -> grants alternate gnt0, gnt1, gnt0, gnt1; never both high.
REQ-033 clear_req and req1 in the same IDLE cycle -> gnt1=0, busy=1 next cycle; gnt1 asserted only after clear_done.
REQ-034 rst=0 asynchronously at clear count 100 -> busy and gnt outputs low without waiting for clk; after release, IDLE, no clear_done.
REQ-035 Write 7'h7F to 8'h00 and read 8'h00 in the same cycle -> char_code returns the old code next cycle and 7'h7F on the following read.
